serial_word_tx: RTL

- Transmit end for the 7-bit word datapath: accepts parallel 7-bit words on a load strobe and buffers them in a small FIFO.
- Emits each word as an asynchronous serial frame on a single line: start bit, 7 data bits LSB first, optional parity bit, stop bit.
- Sits after the enable-gated 7-bit registers. Drives the serial link to the matching receiver.

---
 rtl/serial_word_tx_if.sv | 25 ++
 rtl/serial_word_tx.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/serial_word_tx_if.sv
// Parallel-load / serial-out bundle for serial_word_tx.
// Handshake: the producer may assert load on any edge; the word on din is
// taken only when ready is high on that same edge, otherwise it is dropped
// and overflow latches. tx/busy report the serial side.
interface serial_word_tx_if #(
    parameter int FIFO_AW = 2
);
    logic [6:0]       din;
    logic             load;
    logic             ready;
    logic             tx;
    logic             busy;
    logic [FIFO_AW:0] count;
    logic             overflow;

    modport master (
        output din, load,
        input  ready, tx, busy, count, overflow
    );

    modport slave (
        input  din, load,
        output ready, tx, busy, count, overflow
    );
endinterface

// File: rtl/serial_word_tx.sv
// serial_word_tx: FIFO-buffered 7-bit word transmitter.
// Frame on tx: start(0), 7 data bits LSB first, [even parity], stop(1).
// Optional parity bit enabled by defining SERIAL_WORD_TX_PARITY_EN.
// dbg_state exposes the FSM state encoding for external checkers.
module serial_word_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_AW      = 2
) (
    input  logic                clock,
    input  logic                reset,
    serial_word_tx_if.slave     bus,
    output logic [2:0]          dbg_state
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef SERIAL_WORD_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t             state;
    logic [CW-1:0]      cyc;
    logic [2:0]         bitn;
    logic [6:0]         shift;
    logic               par;
    logic               tx_r;
    logic               busy_r;
    logic [FIFO_AW:0]   count_r;
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic               ovf_r;
    logic [6:0]         mem [DEPTH];

    logic               bit_end;
    logic               push;
    logic               pop;
    logic [6:0]         head;

    // ready comes from the registered count, so a full FIFO rejects a push
    // even when a pop happens on the same edge.
    assign bit_end = (cyc == CW'(CLKS_PER_BIT - 1));
    assign bus.ready = (count_r < (FIFO_AW+1)'(DEPTH));
    assign push    = bus.load && bus.ready;
    assign pop     = (count_r != '0) &&
                     ((state == S_IDLE) || ((state == S_STOP) && bit_end));
    assign head    = mem[rd_ptr];

    assign bus.tx       = tx_r;
    assign bus.busy     = busy_r;
    assign bus.count    = count_r;
    assign bus.overflow = ovf_r;
    assign dbg_state    = state;

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= bus.din;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
            ovf_r   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
            if (bus.load && !bus.ready) begin
                ovf_r <= 1'b1;
            end
        end
    end

    // Frame sequencer: every bit lasts CLKS_PER_BIT cycles; tx and busy are
    // registered and change together with the state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            cyc    <= '0;
            bitn   <= '0;
            shift  <= '0;
            par    <= 1'b0;
            tx_r   <= 1'b1;
            busy_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    cyc  <= '0;
                    tx_r <= 1'b1;
                    if (pop) begin
                        shift  <= head;
                        par    <= ^head;
                        tx_r   <= 1'b0;
                        busy_r <= 1'b1;
                        state  <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        cyc   <= '0;
                        bitn  <= '0;
                        tx_r  <= shift[0];
                        state <= S_DATA;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        cyc <= '0;
                        if (bitn == 3'd6) begin
`ifdef SERIAL_WORD_TX_PARITY_EN
                            tx_r  <= par;
                            state <= S_PARITY;
`else
                            tx_r  <= 1'b1;
                            state <= S_STOP;
`endif
                        end else begin
                            bitn  <= bitn + 1'b1;
                            shift <= shift >> 1;
                            tx_r  <= shift[1];
                        end
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
`ifdef SERIAL_WORD_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        cyc   <= '0;
                        tx_r  <= 1'b1;
                        state <= S_STOP;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_end) begin
                        cyc <= '0;
                        if (pop) begin
                            // Back-to-back: next start bit follows the stop bit directly.
                            shift <= head;
                            par   <= ^head;
                            tx_r  <= 1'b0;
                            state <= S_START;
                        end else begin
                            tx_r   <= 1'b1;
                            busy_r <= 1'b0;
                            state  <= S_IDLE;
                        end
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                default: begin
                    cyc    <= '0;
                    tx_r   <= 1'b1;
                    busy_r <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule
